// File: rtl/camerica_pkg.sv
// rtl/camerica_pkg.sv - camera host register map, bit positions and arbiter types
package camerica_pkg;

    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_IRQ_PEND = 2;
    localparam int REG_IRQ_MASK = 3;

    localparam int N_CTRL        = 3;
    localparam int CTRL_CAPTURE  = 0;
    localparam int CTRL_HISTO    = 1;
    localparam int CTRL_TEST_PAT = 2;

    localparam int N_IRQ         = 3;
    localparam int IRQ_FRAME     = 0;
    localparam int IRQ_HISTO     = 1;
    localparam int IRQ_OVERFLOW  = 2;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    typedef enum logic {HOST_NIOS, HOST_HPS} host_t;

endpackage

// File: rtl/cam_rr_arb2.sv
// rtl/cam_rr_arb2.sv - two-way round-robin arbiter; a tie goes to the host not granted last
module cam_rr_arb2
    import camerica_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output host_t      o_grant,
    output logic       o_valid
);

    host_t r_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= HOST_HPS;
        end else if (i_take && o_valid) begin
            r_last <= o_grant;
        end
    end

    always_comb begin
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_grant = HOST_NIOS;
            2'b10:   o_grant = HOST_HPS;
            2'b11:   o_grant = (r_last == HOST_HPS) ? HOST_NIOS : HOST_HPS;
            default: o_grant = HOST_NIOS;
        endcase
    end

endmodule

// File: rtl/cam_host_reg_arbiter.sv
// rtl/cam_host_reg_arbiter.sv - shares the camera control/status registers between NIOS and HPS buses
module cam_host_reg_arbiter
    import camerica_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nr_bus_enable,
    input  logic              nr_rw,
    input  logic [ADDR_W-1:0] nr_address,
    input  logic [DATA_W-1:0] nr_write_data,
    output logic              nr_acknowledge,
    output logic [DATA_W-1:0] nr_read_data,
    output logic              nr_irq,
    input  logic              hr_bus_enable,
    input  logic              hr_rw,
    input  logic [ADDR_W-1:0] hr_address,
    input  logic [DATA_W-1:0] hr_write_data,
    output logic              hr_acknowledge,
    output logic [DATA_W-1:0] hr_read_data,
    output logic              hr_irq,
    input  logic              evt_frame_done,
    input  logic              evt_histo_ready,
    input  logic              evt_overflow,
    input  logic              stat_locked,
    input  logic              stat_busy,
    output logic              ctrl_capture_en,
    output logic              ctrl_histo_en,
    output logic              ctrl_test_pattern
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    host_t             r_host;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [N_CTRL-1:0] r_ctrl;
    logic [N_IRQ-1:0]  r_pend;
    logic [N_IRQ-1:0]  r_mask_nios;
    logic [N_IRQ-1:0]  r_mask_hps;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic              r_nr_ack;
    logic              r_hr_ack;
    logic [DATA_W-1:0] r_nr_rdata;
    logic [DATA_W-1:0] r_hr_rdata;
    logic              r_nr_irq;
    logic              r_hr_irq;

    logic [1:0]        w_req;
    host_t             w_grant;
    logic              w_grant_valid;
    logic              w_take;
    logic              w_access;
    logic              w_write;
    logic [DATA_W-1:0] w_rdata;
    logic [N_IRQ-1:0]  w_set;
    logic [N_IRQ-1:0]  w_clr;

    assign w_req = {hr_bus_enable, nr_bus_enable};

    cam_rr_arb2 u_arb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (w_req),
        .i_take  (w_take),
        .o_grant (w_grant),
        .o_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:  if (w_grant_valid) w_next_state = ARB_GRANT;
            ARB_GRANT: w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_take   = (r_state == ARB_IDLE) && w_grant_valid;
        w_access = (r_state == ARB_GRANT);
        w_write  = w_access && !r_rw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_host  <= HOST_HPS;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_host  <= w_grant;
            r_rw    <= (w_grant == HOST_NIOS) ? nr_rw : hr_rw;
            r_addr  <= (w_grant == HOST_NIOS) ? nr_address : hr_address;
            r_wdata <= (w_grant == HOST_NIOS) ? nr_write_data : hr_write_data;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (r_addr)
            ADDR_W'(REG_CTRL):     w_rdata[N_CTRL-1:0] = r_ctrl;
            ADDR_W'(REG_STATUS): begin
                w_rdata[FCNT_W-1:0] = r_frame_cnt;
                w_rdata[FCNT_W]     = stat_locked;
                w_rdata[FCNT_W+1]   = stat_busy;
            end
            ADDR_W'(REG_IRQ_PEND): w_rdata[N_IRQ-1:0] = r_pend;
            ADDR_W'(REG_IRQ_MASK): w_rdata[N_IRQ-1:0] = (r_host == HOST_NIOS) ? r_mask_nios : r_mask_hps;
            default:               w_rdata = '0;
        endcase
    end

    // A datapath event always beats a same-cycle W1C of the same bit.
    always_comb begin
        w_set = '0;
        w_set[IRQ_FRAME]    = evt_frame_done;
        w_set[IRQ_HISTO]    = evt_histo_ready;
        w_set[IRQ_OVERFLOW] = evt_overflow;
        w_clr = (w_write && r_addr == ADDR_W'(REG_IRQ_PEND)) ? r_wdata[N_IRQ-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_pend      <= '0;
            r_mask_nios <= '0;
            r_mask_hps  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (evt_frame_done) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            if (w_write && r_addr == ADDR_W'(REG_CTRL)) r_ctrl <= r_wdata[N_CTRL-1:0];
            if (w_write && r_addr == ADDR_W'(REG_IRQ_MASK)) begin
                if (r_host == HOST_NIOS) r_mask_nios <= r_wdata[N_IRQ-1:0];
                else                     r_mask_hps  <= r_wdata[N_IRQ-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nr_ack   <= 1'b0;
            r_hr_ack   <= 1'b0;
            r_nr_rdata <= '0;
            r_hr_rdata <= '0;
            r_nr_irq   <= 1'b0;
            r_hr_irq   <= 1'b0;
        end else begin
            r_nr_ack   <= w_access && (r_host == HOST_NIOS);
            r_hr_ack   <= w_access && (r_host == HOST_HPS);
            r_nr_rdata <= (w_access && r_rw && r_host == HOST_NIOS) ? w_rdata : '0;
            r_hr_rdata <= (w_access && r_rw && r_host == HOST_HPS)  ? w_rdata : '0;
            r_nr_irq   <= |(r_pend & r_mask_nios);
            r_hr_irq   <= |(r_pend & r_mask_hps);
        end
    end

    assign nr_acknowledge    = r_nr_ack;
    assign hr_acknowledge    = r_hr_ack;
    assign nr_read_data      = r_nr_rdata;
    assign hr_read_data      = r_hr_rdata;
    assign nr_irq            = r_nr_irq;
    assign hr_irq            = r_hr_irq;
    assign ctrl_capture_en   = r_ctrl[CTRL_CAPTURE];
    assign ctrl_histo_en     = r_ctrl[CTRL_HISTO];
    assign ctrl_test_pattern = r_ctrl[CTRL_TEST_PAT];

endmodule

// File: tb/tb_cam_host_reg_arbiter.sv
// tb/tb_cam_host_reg_arbiter.sv - scoreboard bench for the shared camera register arbiter
module tb_cam_host_reg_arbiter;

    typedef struct {
        int          host;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        be [2];
    logic        rw [2];
    logic [1:0]  ad [2];
    logic [31:0] wd [2];
    logic [1:0]  ack_v;
    logic [31:0] rd [2];
    logic        nr_acknowledge, hr_acknowledge, nr_irq, hr_irq;
    logic [31:0] nr_read_data, hr_read_data;
    logic        evt_frame_done = 1'b0, evt_histo_ready = 1'b0, evt_overflow = 1'b0;
    logic        stat_locked = 1'b1, stat_busy = 1'b1;
    logic        ctrl_capture_en, ctrl_histo_en, ctrl_test_pattern;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   lat0, lat1;

    always #10 clk = ~clk;

    assign ack_v = {hr_acknowledge, nr_acknowledge};
    assign rd[0] = nr_read_data;
    assign rd[1] = hr_read_data;

    cam_host_reg_arbiter #(.DATA_W(32), .ADDR_W(2), .FCNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .nr_bus_enable     (be[0]),
        .nr_rw             (rw[0]),
        .nr_address        (ad[0]),
        .nr_write_data     (wd[0]),
        .nr_acknowledge    (nr_acknowledge),
        .nr_read_data      (nr_read_data),
        .nr_irq            (nr_irq),
        .hr_bus_enable     (be[1]),
        .hr_rw             (rw[1]),
        .hr_address        (ad[1]),
        .hr_write_data     (wd[1]),
        .hr_acknowledge    (hr_acknowledge),
        .hr_read_data      (hr_read_data),
        .hr_irq            (hr_irq),
        .evt_frame_done    (evt_frame_done),
        .evt_histo_ready   (evt_histo_ready),
        .evt_overflow      (evt_overflow),
        .stat_locked       (stat_locked),
        .stat_busy         (stat_busy),
        .ctrl_capture_en   (ctrl_capture_en),
        .ctrl_histo_en     (ctrl_histo_en),
        .ctrl_test_pattern (ctrl_test_pattern)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_acc(input int h, input bit is_read, input logic [31:0] d);
        exp_t e;
        e.host = h; e.is_read = is_read; e.data = d;
        exp_q.push_back(e);
    endtask

    // Called on a falling edge; returns on the falling edge where ack is seen.
    task automatic access(input int h, input logic r, input logic [1:0] a,
                          input logic [31:0] d, output int lat);
        be[h] = 1'b1; rw[h] = r; ad[h] = a; wd[h] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack_v[h] && lat < 10);
        if (!ack_v[h]) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout host%0d: got no ack expected ack within 10 cycles", h);
        end
        be[h] = 1'b0;
    endtask

    task automatic pulse_frame();
        evt_frame_done = 1'b1;
        @(negedge clk);
        evt_frame_done = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("single_ack", {31'd0, ack_v == 2'b11}, 32'd0);
        for (int h = 0; h < 2; h++) begin
            if (ack_v[h]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack_host", 32'(h), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_host_order", 32'(h), 32'(e.host));
                    if (e.is_read) chk("read_data", rd[h], e.data);
                end
            end else begin
                chk("rdata_zero_idle", rd[h], 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int h = 0; h < 2; h++) begin
            be[h] = 1'b0; rw[h] = 1'b0; ad[h] = 2'd0; wd[h] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'd0, ack_v}, 32'd0);
        chk("rst_irq", {30'd0, nr_irq, hr_irq}, 32'd0);
        chk("rst_ctrl", {29'd0, ctrl_test_pattern, ctrl_histo_en, ctrl_capture_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Tie right after reset: NIOS first, HPS one transaction later.
        expect_acc(0, 1, 32'h0003_0000);
        expect_acc(1, 1, 32'h0003_0000);
        fork
            access(0, 1'b1, 2'd1, 32'd0, lat0);
            access(1, 1'b1, 2'd1, 32'd0, lat1);
        join
        chk("tie_nios_latency", 32'(lat0), 32'd2);
        chk("tie_hps_latency", 32'(lat1), 32'd4);

        expect_acc(0, 0, 32'd0);
        access(0, 1'b0, 2'd0, 32'h5, lat0);
        chk("write_latency", 32'(lat0), 32'd2);
        chk("ctrl_bits_after_5", {29'd0, ctrl_test_pattern, ctrl_histo_en, ctrl_capture_en}, 32'h5);
        expect_acc(0, 1, 32'h5);
        access(0, 1'b1, 2'd0, 32'd0, lat0);

        expect_acc(0, 0, 32'd0);
        access(0, 1'b0, 2'd3, 32'h1, lat0);
        expect_acc(1, 0, 32'd0);
        access(1, 1'b0, 2'd3, 32'h0, lat1);
        repeat (3) pulse_frame();
        chk("nr_irq_set", {31'd0, nr_irq}, 32'd1);
        chk("hr_irq_masked", {31'd0, hr_irq}, 32'd0);
        expect_acc(0, 1, 32'h0003_0003);
        access(0, 1'b1, 2'd1, 32'd0, lat0);
        expect_acc(0, 1, 32'h1);
        access(0, 1'b1, 2'd3, 32'd0, lat0);
        expect_acc(1, 1, 32'h0);
        access(1, 1'b1, 2'd3, 32'd0, lat1);
        expect_acc(1, 0, 32'd0);
        access(1, 1'b0, 2'd2, 32'h1, lat1);
        @(negedge clk);
        chk("nr_irq_cleared", {31'd0, nr_irq}, 32'd0);

        // W1C of bits 2 and 0 while a frame_done lands on the same edge.
        evt_overflow = 1'b1;
        @(negedge clk);
        evt_overflow = 1'b0;
        expect_acc(1, 0, 32'd0);
        fork
            access(1, 1'b0, 2'd2, 32'h5, lat1);
            begin
                @(negedge clk);
                evt_frame_done = 1'b1;
                @(negedge clk);
                evt_frame_done = 1'b0;
            end
        join
        expect_acc(0, 1, 32'h1);
        access(0, 1'b1, 2'd2, 32'd0, lat0);
        expect_acc(0, 1, 32'h0003_0004);
        access(0, 1'b1, 2'd1, 32'd0, lat0);

        evt_frame_done = 1'b1;
        repeat (65531) @(negedge clk);
        evt_frame_done = 1'b0;
        expect_acc(1, 1, 32'h0003_FFFF);
        access(1, 1'b1, 2'd1, 32'd0, lat1);
        pulse_frame();
        expect_acc(1, 1, 32'h0003_0000);
        access(1, 1'b1, 2'd1, 32'd0, lat1);
        pulse_frame();

        // Reset lands on the GRANT cycle of an HPS write.
        be[1] = 1'b1; rw[1] = 1'b0; ad[1] = 2'd0; wd[1] = 32'h7;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_grant_ack", {30'd0, ack_v}, 32'd0);
        chk("rst_mid_grant_ctrl", {29'd0, ctrl_test_pattern, ctrl_histo_en, ctrl_capture_en}, 32'd0);
        be[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        expect_acc(1, 0, 32'd0);
        access(1, 1'b0, 2'd0, 32'h7, lat1);
        chk("ctrl_after_reissue", {29'd0, ctrl_test_pattern, ctrl_histo_en, ctrl_capture_en}, 32'h7);
        expect_acc(0, 1, 32'h0003_0000);
        expect_acc(1, 1, 32'h0);
        fork
            access(0, 1'b1, 2'd1, 32'd0, lat0);
            access(1, 1'b1, 2'd3, 32'd0, lat1);
        join
        expect_acc(0, 1, 32'h0);
        access(0, 1'b1, 2'd3, 32'd0, lat0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
